// File: rtl/mimc_pkg.sv
// Shared definitions for the MiMC-Feistel hash slice: field prime, default sizes,
// sequencer state encoding and the round-index type.
package mimc_pkg;

  localparam int unsigned DEF_ROUNDS = 220;
  localparam int unsigned DEF_WIDTH  = 256;

  // Dark Forest (BN254 scalar field) prime
  localparam logic [255:0] PRIME =
    256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef logic [7:0] round_idx_t;

endpackage

// File: rtl/mimc_round_sequencer.sv
// Drives one MiMC-Feistel permutation through an external single-round core,
// feeding each round result back and un-swapping the final one.
module mimc_round_sequencer
  import mimc_pkg::*;
#(
  parameter int unsigned ROUNDS      = DEF_ROUNDS,
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_xl,
  input  logic [WIDTH-1:0] in_xr,
  input  logic [WIDTH-1:0] in_key,
  input  logic             abort,
  output logic             rnd_valid,
  output round_idx_t       rnd_idx,
  output logic             rnd_last,
  output logic [WIDTH-1:0] rnd_xl,
  output logic [WIDTH-1:0] rnd_xr,
  output logic [WIDTH-1:0] rnd_key,
  input  logic             core_valid,
  input  logic [WIDTH-1:0] core_xl,
  input  logic [WIDTH-1:0] core_xr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_xl,
  output logic [WIDTH-1:0] out_xr,
  output logic             busy,
  output logic             err
);

  localparam int unsigned WDW = unsigned'($clog2(WDOG_CYCLES + 1));
  localparam round_idx_t LAST_IDX = round_idx_t'(ROUNDS - 1);
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(WDOG_CYCLES - 1);

  state_t         state;
  logic [WDW-1:0] wdog;
  logic           accept;
  logic           spurious;
  logic           timeout;

  always_comb begin
    accept   = (state == ST_IDLE) && in_ready && in_valid && !abort;
    spurious = core_valid && (state != ST_WAIT);
    timeout  = (state == ST_WAIT) && !core_valid && (wdog == WDOG_LAST);
  end

  // The rnd_* registers double as the working xl/xr/key state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wdog      <= '0;
      in_ready  <= 1'b0;
      rnd_valid <= 1'b0;
      rnd_idx   <= '0;
      rnd_last  <= 1'b0;
      rnd_xl    <= '0;
      rnd_xr    <= '0;
      rnd_key   <= '0;
      out_valid <= 1'b0;
      out_xl    <= '0;
      out_xr    <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      rnd_valid <= 1'b0;
      if (abort && (state != ST_IDLE)) begin
        state     <= ST_IDLE;
        out_valid <= 1'b0;
        busy      <= 1'b0;
        in_ready  <= 1'b1;
      end else begin
        if (spurious) err <= 1'b1;
        case (state)
          ST_IDLE: begin
            in_ready <= 1'b1;
            if (accept) begin
              rnd_xl    <= in_xl;
              rnd_xr    <= in_xr;
              rnd_key   <= in_key;
              rnd_idx   <= '0;
              rnd_last  <= 1'b0;
              err       <= spurious;
              rnd_valid <= 1'b1;
              in_ready  <= 1'b0;
              busy      <= 1'b1;
              state     <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            wdog  <= '0;
            state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (core_valid) begin
              if (rnd_last) begin
                out_xl    <= core_xr;
                out_xr    <= core_xl;
                out_valid <= 1'b1;
                state     <= ST_DONE;
              end else begin
                rnd_xl    <= core_xl;
                rnd_xr    <= core_xr;
                rnd_idx   <= rnd_idx + 8'd1;
                rnd_last  <= (rnd_idx + 8'd1) == LAST_IDX;
                rnd_valid <= 1'b1;
                state     <= ST_ISSUE;
              end
            end else if (timeout) begin
              err      <= 1'b1;
              busy     <= 1'b0;
              in_ready <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              wdog <= wdog + WDW'(1);
            end
          end
          ST_DONE: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
              state     <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
